// File: rtl/adc_spi_pkg.sv
// Shared definitions for the LTC1407A/LTC6912 capture path: FSM encoding and frame layout.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AMP_SHIFT,
    AMP_END,
    CONV,
    ADC_SHIFT,
    DONE
  } adc_state_t;

  // Frame layout: bit index k counts SCK periods from the start of the read.
  localparam int FRAME_BITS    = 34;
  localparam int CH0_FIRST_BIT = 2;
  localparam int CH1_FIRST_BIT = 18;
  localparam int AMP_BITS      = 8;

endpackage

// File: rtl/adc_spi_capture_sck_tick_gen.sv
// SPI serial clock generator: toggles sck every SCK_DIV cycles while enabled and flags
// the cycle before each rise and fall.
module spi_sck_tick_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic enable,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(SCK_DIV);

  logic [CW-1:0] div_cnt;
  logic          half_done;

  assign half_done = enable && (div_cnt == CW'(SCK_DIV - 1));
  assign rise_tick = half_done && !sck;
  assign fall_tick = half_done && sck;

  // Holding the divider clear while disabled restarts the phase at 0 on every enable.
  always_ff @(posedge qzt_clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Programs the LTC6912 preamp gain and captures one LTC1407A dual-channel conversion
// over the shared SPI bus.
module adc_spi_capture
  import adc_spi_pkg::*;
#(
  parameter int SCK_DIV  = 4,
  parameter int SAMPLE_W = 14
) (
  input  logic                qzt_clk,
  input  logic                reset,
  input  logic                start,
  input  logic                gain_load,
  input  logic [3:0]          gain_a,
  input  logic [3:0]          gain_b,
  input  logic                SPI_MISO,
  output logic                SPI_SCK,
  output logic                SPI_MOSI,
  output logic                AD_CONV,
  output logic                AMP_CS,
  output logic                AMP_SHDN,
  output logic [SAMPLE_W-1:0] ch0,
  output logic [SAMPLE_W-1:0] ch1,
  output logic                sample_valid,
  output logic                busy
);

  localparam int WAIT_CYCLES = 2 * SCK_DIV;
  localparam int WW          = $clog2(WAIT_CYCLES);
  localparam int BW          = $clog2(FRAME_BITS + 1);
  // Only bits from k=CH0_FIRST_BIT onward are ever published, so earlier bits shift out.
  localparam int SR_W        = FRAME_BITS - CH0_FIRST_BIT;
  localparam int CH1_MSB     = FRAME_BITS - 1 - CH1_FIRST_BIT;

  adc_state_t          state_q, state_d;
  logic [BW-1:0]       bit_cnt;
  logic [WW-1:0]       wait_cnt;
  logic [AMP_BITS-1:0] amp_cmd;
  logic [AMP_BITS-1:0] amp_sr;
  logic [SR_W-1:0]     frame_sr;
  logic                shift_en, rise_tick, fall_tick;
  logic                wait_done, amp_last, frame_last;

  assign amp_cmd    = {gain_b, gain_a};
  assign shift_en   = (state_q == AMP_SHIFT) || (state_q == ADC_SHIFT);
  assign wait_done  = (wait_cnt == WW'(WAIT_CYCLES - 1));
  assign amp_last   = fall_tick && (bit_cnt == BW'(AMP_BITS - 1));
  assign frame_last = fall_tick && (bit_cnt == BW'(FRAME_BITS - 1));
  assign busy       = (state_q != IDLE);

  spi_sck_tick_gen #(
    .SCK_DIV(SCK_DIV)
  ) u_sck (
    .qzt_clk  (qzt_clk),
    .reset    (reset),
    .enable   (shift_en),
    .sck      (SPI_SCK),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge qzt_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A preamp load wins over a simultaneous start; the start is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gain_load)  state_d = AMP_SHIFT;
        else if (start) state_d = CONV;
      end
      AMP_SHIFT: if (amp_last)   state_d = AMP_END;
      AMP_END:   if (wait_done)  state_d = IDLE;
      CONV:      if (wait_done)  state_d = ADC_SHIFT;
      ADC_SHIFT: if (frame_last) state_d = DONE;
      DONE:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge qzt_clk) begin
    if (reset || (state_d != state_q)) begin
      bit_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
      if (fall_tick) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // The command register shifts in zeros, so MOSI falls back to 0 on the final fall.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      SPI_MOSI     <= 1'b0;
      AD_CONV      <= 1'b0;
      AMP_CS       <= 1'b1;
      AMP_SHDN     <= 1'b1;
      ch0          <= '0;
      ch1          <= '0;
      sample_valid <= 1'b0;
      amp_sr       <= '0;
      frame_sr     <= '0;
    end else begin
      AMP_SHDN     <= 1'b0;
      AD_CONV      <= (state_d == CONV);
      AMP_CS       <= (state_d != AMP_SHIFT);
      sample_valid <= (state_q == DONE);

      if ((state_q == IDLE) && gain_load) begin
        SPI_MOSI <= amp_cmd[AMP_BITS-1];
        amp_sr   <= {amp_cmd[AMP_BITS-2:0], 1'b0};
      end else if ((state_q == AMP_SHIFT) && fall_tick) begin
        SPI_MOSI <= amp_sr[AMP_BITS-1];
        amp_sr   <= {amp_sr[AMP_BITS-2:0], 1'b0};
      end

      if ((state_q == ADC_SHIFT) && rise_tick)
        frame_sr <= {frame_sr[SR_W-2:0], SPI_MISO};

      if (state_q == DONE) begin
        ch0 <= frame_sr[SR_W-1 -: SAMPLE_W];
        ch1 <= frame_sr[CH1_MSB -: SAMPLE_W];
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture: a MISO frame model, preamp command capture on SCK rises.
module tb_adc_spi_capture;

  logic        qzt_clk = 1'b0;
  logic        reset, start, gain_load;
  logic [3:0]  gain_a, gain_b;
  logic        SPI_MISO;
  logic        SPI_SCK, SPI_MOSI, AD_CONV, AMP_CS, AMP_SHDN;
  logic [13:0] ch0, ch1;
  logic        sample_valid, busy;

  int          pass_cnt  = 0;
  int          check_cnt = 0;
  logic [33:0] tx_frame  = '0;
  int          miso_idx;
  logic        prev_sck_model;

  always #10 qzt_clk = ~qzt_clk;

  adc_spi_capture #(
    .SCK_DIV (4),
    .SAMPLE_W(14)
  ) dut (
    .qzt_clk     (qzt_clk),
    .reset       (reset),
    .start       (start),
    .gain_load   (gain_load),
    .gain_a      (gain_a),
    .gain_b      (gain_b),
    .SPI_MISO    (SPI_MISO),
    .SPI_SCK     (SPI_SCK),
    .SPI_MOSI    (SPI_MOSI),
    .AD_CONV     (AD_CONV),
    .AMP_CS      (AMP_CS),
    .AMP_SHDN    (AMP_SHDN),
    .ch0         (ch0),
    .ch1         (ch1),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  // ADC model: bit k of tx_frame (MSB first) is presented after the k-th SCK fall.
  initial begin
    SPI_MISO       = 1'b0;
    miso_idx       = 0;
    prev_sck_model = 1'b0;
    forever begin
      @(negedge qzt_clk);
      if (AD_CONV) miso_idx = 0;
      else if (prev_sck_model && !SPI_SCK) miso_idx++;
      prev_sck_model = SPI_SCK;
      SPI_MISO = (miso_idx < 34) ? tx_frame[33 - miso_idx] : 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge qzt_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic g, input logic [3:0] ga,
                               input logic [3:0] gb);
    @(negedge qzt_clk);
    start     = s;
    gain_load = g;
    gain_a    = ga;
    gain_b    = gb;
    tick();
    start     = 1'b0;
    gain_load = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sck"},   SPI_SCK,      0);
    checkOutput({tag, "_mosi"},  SPI_MOSI,     0);
    checkOutput({tag, "_conv"},  AD_CONV,      0);
    checkOutput({tag, "_cs"},    AMP_CS,       1);
    checkOutput({tag, "_shdn"},  AMP_SHDN,     1);
    checkOutput({tag, "_ch0"},   ch0,          0);
    checkOutput({tag, "_ch1"},   ch1,          0);
    checkOutput({tag, "_valid"}, sample_valid, 0);
    checkOutput({tag, "_busy"},  busy,         0);
  endtask

  // One conversion; optionally re-asserts start for one cycle at poke_cycle while busy.
  task automatic runCapture(input logic [13:0] e0, input logic [13:0] e1, input string tag,
                            input int poke_cycle);
    int cycles;
    int conv_cycles;
    cycles = 0;
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    checkOutput({tag, "_busy_on"}, busy, 1);
    conv_cycles = int'(AD_CONV);
    while (!sample_valid && cycles < 400) begin
      start = (cycles == poke_cycle);
      tick();
      cycles++;
      if (AD_CONV) conv_cycles++;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, cycles, 281);
    checkOutput({tag, "_conv_len"}, conv_cycles, 8);
    checkOutput({tag, "_ch0"}, ch0, e0);
    checkOutput({tag, "_ch1"}, ch1, e1);
    tick();
    checkOutput({tag, "_valid_off"}, sample_valid, 0);
    checkOutput({tag, "_busy_off"}, busy, 0);
  endtask

  task automatic runAmpLoad(input logic s, input logic [3:0] ga, input logic [3:0] gb,
                            input logic [7:0] exp_word, input string tag);
    int cycles, rises, conv, valids, cs_bad;
    logic [7:0] word;
    logic prev;
    cycles = 0; rises = 0; conv = 0; valids = 0; cs_bad = 0;
    word = '0;
    prev = 1'b0;
    applyStimulus(s, 1'b1, ga, gb);
    checkOutput({tag, "_cs_low"}, AMP_CS, 0);
    while (busy && cycles < 200) begin
      if (SPI_SCK && !prev) begin
        rises++;
        word = {word[6:0], SPI_MOSI};
        if (AMP_CS) cs_bad++;
      end
      prev = SPI_SCK;
      conv += int'(AD_CONV);
      valids += int'(sample_valid);
      tick();
      cycles++;
    end
    checkOutput({tag, "_busy_len"}, cycles, 72);
    checkOutput({tag, "_rises"}, rises, 8);
    checkOutput({tag, "_word"}, word, exp_word);
    checkOutput({tag, "_cs_during"}, cs_bad, 0);
    checkOutput({tag, "_cs_high"}, AMP_CS, 1);
    checkOutput({tag, "_mosi_idle"}, SPI_MOSI, 0);
    checkOutput({tag, "_no_conv"}, conv, 0);
    checkOutput({tag, "_no_valid"}, valids, 0);
  endtask

  initial begin
    int extra_valid, extra_conv;
    reset     = 1'b1;
    start     = 1'b0;
    gain_load = 1'b0;
    gain_a    = 4'h0;
    gain_b    = 4'h0;
    repeat (3) tick();
    checkResetValues("rst");
    @(negedge qzt_clk);
    reset = 1'b0;
    tick();
    checkOutput("shdn_released", AMP_SHDN, 0);

    tx_frame = {2'b00, 14'h1ABC, 2'b00, 14'h2345, 2'b00};
    runCapture(14'h1ABC, 14'h2345, "cap1", -1);

    tx_frame = {2'b11, 14'h3FFF, 2'b11, 14'h0000, 2'b11};
    runCapture(14'h3FFF, 14'h0000, "cap2", -1);

    runAmpLoad(1'b0, 4'h1, 4'h3, 8'h31, "amp");
    runAmpLoad(1'b1, 4'hA, 4'h5, 8'h5A, "both");
    checkOutput("hold_ch0", ch0, 14'h3FFF);
    checkOutput("hold_ch1", ch1, 14'h0000);

    tx_frame = {2'b01, 14'h0155, 2'b10, 14'h2AAA, 2'b01};
    runCapture(14'h0155, 14'h2AAA, "busy_start", 100);
    extra_valid = 0;
    extra_conv  = 0;
    repeat (320) begin
      tick();
      extra_valid += int'(sample_valid);
      extra_conv  += int'(AD_CONV);
    end
    checkOutput("busy_start_extra_valid", extra_valid, 0);
    checkOutput("busy_start_extra_conv", extra_conv, 0);

    tx_frame = {2'b00, 14'h1ABC, 2'b00, 14'h2345, 2'b00};
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    repeat (171) tick();
    @(negedge qzt_clk);
    reset = 1'b1;
    tick();
    checkResetValues("abort");
    @(negedge qzt_clk);
    reset = 1'b0;
    tick();

    tx_frame = {2'b10, 14'h0F0F, 2'b01, 14'h3C3C, 2'b11};
    runCapture(14'h0F0F, 14'h3C3C, "cap3", -1);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
